// File: rtl/wb_cfg_initiator.sv
// Wishbone classic single-transfer initiator: each accepted command becomes one bus cycle and one response pulse.
// Build option: define WB_CFG_TIMEOUT_EN to include the ack timeout counter and the rsp_err path.

module wb_cfg_initiator #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i
);

    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("wb_cfg_initiator: DATA_W must be a multiple of 8");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("wb_cfg_initiator: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_hs;
    logic   w_timeout;
    logic   w_done;

    assign w_hs   = cmd_valid & cmd_ready;
    assign w_done = (r_state == S_BUS) && (wbm_ack_i || w_timeout);

`ifdef WB_CFG_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Counter is zeroed while idle, so it reads k-1 on the k-th edge spent in BUS.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            r_cnt <= '0;
        end else if (r_state == S_BUS) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_BUS) && (r_cnt == 16'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_next = S_BUS;
            S_BUS:   if (wbm_ack_i || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake and bus strobes are registered from the next state to keep every output a flop.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            r_state   <= S_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else begin
            r_state   <= w_next;
            cmd_ready <= (w_next == S_IDLE);
            rsp_valid <= (w_next == S_RESP);
            wbm_cyc_o <= (w_next == S_BUS);
            wbm_stb_o <= (w_next == S_BUS);
            if (w_hs) begin
                wbm_we_o  <= cmd_we;
                wbm_adr_o <= cmd_addr;
                wbm_dat_o <= cmd_wdata;
                wbm_sel_o <= cmd_sel;
            end
            // Ack takes priority over a coincident timeout.
            if (w_done) begin
                rsp_err   <= !wbm_ack_i;
                rsp_rdata <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_cfg_initiator.sv
// Self-checking bench for wb_cfg_initiator: directed scenarios plus randomized transfers against a cycle-count model.
module tb_wb_cfg_initiator;

    localparam int TO = 4;
`ifdef WB_CFG_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_cfg_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    // Cycle indices count negedges after the handshake edge (0 = first cycle after it).
    typedef struct {
        int          cyc;
        int          rsp;
        int          rdy;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          cyc;
        int          rsp;
        int          pulses;
        int          rdy;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] rdata_hold;
        logic        hold_ok;
    } obs_t;

    // w = number of wait cycles before the target acks, -1 = never acks.
    function automatic exp_t model(input logic we, input int w, input logic [31:0] d);
        exp_t e;
        bit   to;
        to      = TO_EN && ((w < 0) || (w >= TO));
        e.cyc   = to ? TO : w + 1;
        e.rsp   = e.cyc;
        e.rdy   = e.cyc + 1;
        e.err   = to;
        e.rdata = (to || we) ? 32'h0 : d;
        return e;
    endfunction

    task automatic run_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] sel, input int w, input logic [31:0] d, output obs_t o);
        bit done;
        o.cyc = 0; o.rsp = -1; o.pulses = 0; o.rdy = -1; o.err = 1'bx;
        o.rdata = 'x; o.rdata_hold = 'x; o.hold_ok = 1'b1;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_sel = 4'($urandom);
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            wbm_ack_i = 1'b0; wbm_dat_i = $urandom;
            if (wbm_cyc_o === 1'b1) begin
                o.cyc++;
                if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== addr ||
                    wbm_dat_o !== wdata || wbm_sel_o !== sel) o.hold_ok = 1'b0;
                if (w >= 0 && o.cyc - 1 == w) begin wbm_ack_i = 1'b1; wbm_dat_i = d; end
            end
            if (rsp_valid === 1'b1) begin o.pulses++; o.rsp = c; o.rdata = rsp_rdata; o.err = rsp_err; end
            if (cmd_ready === 1'b1) begin
                o.rdy = c; o.rdata_hold = rsp_rdata; done = 1'b1;
            end else begin
                @(posedge clk); @(negedge clk);
            end
        end
        wbm_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; cmd_valid = 1'b0; wbm_ack_i = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        n_tests++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err} !== 5'b0) begin n_fail++;
            $display("FAIL reset_ctl got %b want 00000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err}); end
        n_tests++; if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_rdata} !== 100'h0) begin n_fail++;
            $display("FAIL reset_data got %h want 0", {wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_rdata}); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        obs_t o; exp_t e;
        e = model(1'b1, 0, 32'h0);
        run_xfer(1'b1, 32'h3000_0000, 32'hA5A5_0001, 4'hF, 0, $urandom, o);
        n_tests++; if (o.hold_ok !== 1'b1) begin n_fail++; $display("FAIL wr_hold got %b want 1", o.hold_ok); end
        n_tests++; if (o.pulses !== 1) begin n_fail++; $display("FAIL wr_pulses got %0d want 1", o.pulses); end
        n_tests++; if (o.err !== e.err || o.rdata !== e.rdata) begin n_fail++;
            $display("FAIL wr_rsp got err=%b rdata=%h want err=%b rdata=%h", o.err, o.rdata, e.err, e.rdata); end
        n_tests++; if (o.rdy !== e.rdy) begin n_fail++; $display("FAIL wr_ready_cycle got %0d want %0d", o.rdy, e.rdy); end
    endtask

    task automatic test_read();
        obs_t o; exp_t e; int w;
        w = TO_EN ? TO - 2 : 5;
        e = model(1'b0, w, 32'hDEAD_BEEF);
        run_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, w, 32'hDEAD_BEEF, o);
        n_tests++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL rd_rdata got %h want %h", o.rdata, e.rdata); end
        n_tests++; if (o.rsp !== e.rsp) begin n_fail++; $display("FAIL rd_rsp_cycle got %0d want %0d", o.rsp, e.rsp); end
        n_tests++; if (o.cyc !== e.cyc) begin n_fail++; $display("FAIL rd_cyc_len got %0d want %0d", o.cyc, e.cyc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [8];
        logic [31:0] issued [$];
        int          rsp_cyc [$];
        int          sent, bad_addr, bad_gap, errs;
        for (int i = 0; i < 8; i++) addrs[i] = $urandom & 32'hFFFF_FFFC;
        sent = 0; cmd_we = 1'b1; errs = 0;
        for (int c = 0; c < 60 && rsp_cyc.size() < 8; c++) begin
            wbm_ack_i = 1'b0;
            if (wbm_cyc_o === 1'b1) begin issued.push_back(wbm_adr_o); wbm_ack_i = 1'b1; wbm_dat_i = $urandom; end
            if (rsp_valid === 1'b1) begin rsp_cyc.push_back(c); if (rsp_err !== 1'b0) errs++; end
            if (cmd_ready === 1'b1) begin
                if (sent < 8) begin
                    cmd_valid = 1'b1; cmd_addr = addrs[sent]; cmd_wdata = $urandom; cmd_sel = 4'hF; sent++;
                end else cmd_valid = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
        cmd_valid = 1'b0; wbm_ack_i = 1'b0;
        bad_addr = 0; bad_gap = 0;
        for (int i = 0; i < 8 && i < issued.size(); i++) if (issued[i] !== addrs[i]) bad_addr++;
        for (int i = 1; i < rsp_cyc.size(); i++) if (rsp_cyc[i] - rsp_cyc[i-1] != 3) bad_gap++;
        n_tests++; if (rsp_cyc.size() !== 8) begin n_fail++; $display("FAIL b2b_pulses got %0d want 8", rsp_cyc.size()); end
        n_tests++; if (issued.size() !== 8) begin n_fail++; $display("FAIL b2b_issued got %0d want 8", issued.size()); end
        n_tests++; if (bad_addr !== 0) begin n_fail++; $display("FAIL b2b_addr_order got %0d bad want 0", bad_addr); end
        n_tests++; if (bad_gap !== 0) begin n_fail++; $display("FAIL b2b_spacing got %0d bad gaps want 0", bad_gap); end
        n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL b2b_err got %0d want 0", errs); end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e; int w;
        w = TO_EN ? -1 : 20;
        e = model(1'b0, w, 32'hCAFE_F00D);
        run_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, w, 32'hCAFE_F00D, o);
        n_tests++; if (o.cyc !== e.cyc) begin n_fail++; $display("FAIL to_cyc_len got %0d want %0d", o.cyc, e.cyc); end
        n_tests++; if (o.err !== e.err) begin n_fail++; $display("FAIL to_err got %b want %b", o.err, e.err); end
        n_tests++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL to_rdata got %h want %h", o.rdata, e.rdata); end
        n_tests++; if (o.pulses !== 1 || o.rsp !== e.rsp) begin n_fail++;
            $display("FAIL to_rsp got pulses=%0d cycle=%0d want 1/%0d", o.pulses, o.rsp, e.rsp); end
        e = model(1'b0, 1, 32'h0BAD_CAFE);
        run_xfer(1'b0, 32'h3000_0014, 32'h0, 4'h3, 1, 32'h0BAD_CAFE, o);
        n_tests++; if (o.err !== e.err || o.rdata !== e.rdata) begin n_fail++;
            $display("FAIL to_followup got err=%b rdata=%h want err=%b rdata=%h", o.err, o.rdata, e.err, e.rdata); end
    endtask

    task automatic test_last_cycle_ack();
        obs_t o; exp_t e;
        e = model(1'b0, TO - 1, 32'h1357_9BDF);
        run_xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, TO - 1, 32'h1357_9BDF, o);
        n_tests++; if (o.err !== e.err) begin n_fail++; $display("FAIL last_ack_err got %b want %b", o.err, e.err); end
        n_tests++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL last_ack_rdata got %h want %h", o.rdata, e.rdata); end
    endtask

    task automatic test_ack_outside();
        obs_t o; exp_t e; int anomalies;
        e = model(1'b0, 0, 32'h2468_ACE0);
        run_xfer(1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 32'h2468_ACE0, o);
        anomalies = 0;
        for (int c = 0; c < 4; c++) begin
            wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
            @(posedge clk); @(negedge clk);
            if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) anomalies++;
        end
        wbm_ack_i = 1'b0;
        n_tests++; if (anomalies !== 0) begin n_fail++; $display("FAIL stray_ack got %0d anomalies want 0", anomalies); end
        n_tests++; if (rsp_rdata !== e.rdata) begin n_fail++; $display("FAIL stray_ack_hold got %h want %h", rsp_rdata, e.rdata); end
    endtask

    task automatic test_random();
        obs_t o; exp_t e; logic we; logic [31:0] a, wd, d; logic [3:0] s; int w;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom); a = $urandom; wd = $urandom; d = $urandom; s = 4'($urandom);
            w = int'($urandom_range(0, 6));
            if (TO_EN && $urandom_range(0, 4) == 0) w = -1;
            e = model(we, w, d);
            run_xfer(we, a, wd, s, w, d, o);
            n_tests++; if (o.hold_ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_hold got %b want 1", i, o.hold_ok); end
            n_tests++; if (o.cyc !== e.cyc || o.rsp !== e.rsp || o.rdy !== e.rdy || o.pulses !== 1) begin n_fail++;
                $display("FAIL rnd%0d_timing got cyc=%0d rsp=%0d rdy=%0d n=%0d want %0d/%0d/%0d/1",
                         i, o.cyc, o.rsp, o.rdy, o.pulses, e.cyc, e.rsp, e.rdy); end
            n_tests++; if (o.err !== e.err || o.rdata !== e.rdata || o.rdata_hold !== e.rdata) begin n_fail++;
                $display("FAIL rnd%0d_rsp got err=%b rdata=%h hold=%h want err=%b rdata=%h",
                         i, o.err, o.rdata, o.rdata_hold, e.err, e.rdata); end
        end
    endtask

    task automatic test_reset_mid_bus();
        obs_t o; int pulses, cycs;
        run_xfer(1'b0, 32'h3000_0040, 32'h0, 4'hF, 0, 32'h7777_1111, o);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0044; cmd_wdata = 32'h55AA_55AA; cmd_sel = 4'hF;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        n_tests++; if (wbm_cyc_o !== 1'b1) begin n_fail++; $display("FAIL mid_pending_cyc got %b want 1", wbm_cyc_o); end
        rstn = 1'b0;
        @(posedge clk); @(negedge clk);
        rstn = 1'b1;
        n_tests++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err} !== 5'b0) begin n_fail++;
            $display("FAIL mid_rst_ctl got %b want 00000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err}); end
        n_tests++; if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_rdata} !== 100'h0) begin n_fail++;
            $display("FAIL mid_rst_data got %h want 0", {wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_rdata}); end
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b want 1", cmd_ready); end
        pulses = 0; cycs = 0;
        for (int c = 0; c < 8; c++) begin
            wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
            @(posedge clk); @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
            if (wbm_cyc_o === 1'b1) cycs++;
        end
        wbm_ack_i = 1'b0;
        n_tests++; if (pulses !== 0 || cycs !== 0) begin n_fail++;
            $display("FAIL mid_rst_quiet got rsp=%0d cyc=%0d want 0/0", pulses, cycs); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_last_cycle_ack();
        test_ack_outside();
        test_random();
        test_reset_mid_bus();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
